// File: rtl/cpu_pkg.sv
// Shared types and constants for the RISC-V pipeline front end.
package cpu_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 -- the canonical bubble instruction
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for a fetch response that arrives while IF/ID is stalled.
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            write,
    input  logic            clear,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    // Clear wins over write so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= XLEN'(NOP_INSTR);
        end else if (clear) begin
            valid <= 1'b0;
        end else if (write) begin
            valid <= 1'b1;
            pc    <= wr_pc;
            instr <= wr_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a single-outstanding req/ready + rvalid
// handshake, and drives the IF/ID pipeline register consumed by ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            pc_write_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            if_id_valid_o
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            kill;

    logic            fb_valid;
    logic [XLEN-1:0] fb_pc;
    logic [XLEN-1:0] fb_instr;

    logic            accept;
    logic            resp;
    logic            resp_keep;
    logic            if_id_load;
    logic            bypass;
    logic            fb_write;
    logic            fb_clear;

    // No new request while the buffer is occupied, so at most one response is ever parked.
    assign imem_req_o  = (state_q == REQ) && pc_write_i && !fb_valid;
    assign imem_addr_o = fetch_pc;

    assign accept     = imem_req_o && imem_ready_i;
    assign resp       = (state_q == WAIT) && imem_rvalid_i;
    assign resp_keep  = resp && !kill && !flush_i;
    assign if_id_load = !flush_i && !stall_i;
    assign bypass     = resp_keep && if_id_load && !fb_valid;
    assign fb_write   = resp_keep && !bypass;
    assign fb_clear   = flush_i || (if_id_load && fb_valid);

    fetch_buf #(.XLEN(XLEN)) u_fetch_buf (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .write    (fb_write),
        .clear    (fb_clear),
        .wr_pc    (inflight_pc),
        .wr_instr (imem_rdata_i),
        .valid    (fb_valid),
        .pc       (fb_pc),
        .instr    (fb_instr)
    );

    // Next-state logic for the request/response sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)       state_d = REQ;
            REQ:     if (accept)        state_d = WAIT;
            WAIT:    if (imem_rvalid_i) state_d = REQ;
            default:                    state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, in-flight address and the kill flag that discards a response orphaned by a redirect.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            kill        <= 1'b0;
        end else begin
            if (flush_i) begin
                fetch_pc <= branch_target_i;
            end else if (accept) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (accept) begin
                inflight_pc <= fetch_pc;
            end
            if (resp && kill) begin
                kill <= 1'b0;
            end
            if (flush_i && (((state_q == WAIT) && !imem_rvalid_i) || accept)) begin
                kill <= 1'b1;
            end
        end
    end

    // IF/ID register: flush bubbles, stall holds, otherwise buffer first, then bypass, then bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_id_pc_o    <= '0;
            if_id_instr_o <= XLEN'(NOP_INSTR);
            if_id_valid_o <= 1'b0;
        end else if (flush_i) begin
            if_id_instr_o <= XLEN'(NOP_INSTR);
            if_id_valid_o <= 1'b0;
        end else if (!stall_i) begin
            if (fb_valid) begin
                if_id_pc_o    <= fb_pc;
                if_id_instr_o <= fb_instr;
                if_id_valid_o <= 1'b1;
            end else if (bypass) begin
                if_id_pc_o    <= inflight_pc;
                if_id_instr_o <= imem_rdata_i;
                if_id_valid_o <= 1'b1;
            end else begin
                if_id_instr_o <= XLEN'(NOP_INSTR);
                if_id_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction-level model plus directed scenarios.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        pc_write_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;

    // Requested stimulus, applied at the next falling edge
    bit          s_rst, s_start, s_pc_write, s_stall, s_flush, s_ready, s_rvalid_en;
    logic [31:0] s_target;

    // Instruction memory environment
    bit          mem_pending;
    logic [31:0] mem_addr;

    // Behavioural model of the fetch stage
    bit          m_running, m_waiting, m_kill, m_fbv, m_ifv;
    logic [31:0] m_npc, m_inflight, m_fbpc, m_fbin, m_ifpc, m_ifin;

    int          checks;
    int          errors;
    logic [31:0] req_log[$];
    logic [31:0] pc_log[$];
    bit          prev_valid;
    logic [31:0] prev_pc;

    always #5 clk_i = ~clk_i;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .pc_write_i      (pc_write_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o)
    );

    function automatic logic [31:0] instr_for(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_running  = 0;
        m_waiting  = 0;
        m_kill     = 0;
        m_fbv      = 0;
        m_ifv      = 0;
        m_npc      = 32'h0;
        m_inflight = 32'h0;
        m_fbpc     = 32'h0;
        m_fbin     = NOP;
        m_ifpc     = 32'h0;
        m_ifin     = NOP;
    endtask

    function automatic bit model_req();
        return rst_i && m_running && !m_waiting && pc_write_i && !m_fbv;
    endfunction

    // Advance the model by one clock edge from the inputs currently applied.
    task automatic model_step();
        bit          acc;
        bit          resp;
        bit          got;
        logic [31:0] old_npc;
        acc     = model_req() && imem_ready_i;
        resp    = m_running && m_waiting && imem_rvalid_i;
        got     = resp && !m_kill && !flush_i;
        old_npc = m_npc;

        if (flush_i) begin
            m_ifv  = 0;
            m_ifin = NOP;
            m_fbv  = 0;
        end else if (!stall_i) begin
            if (m_fbv) begin
                m_ifv  = 1;
                m_ifpc = m_fbpc;
                m_ifin = m_fbin;
                m_fbv  = 0;
            end else if (got) begin
                m_ifv  = 1;
                m_ifpc = m_inflight;
                m_ifin = imem_rdata_i;
            end else begin
                m_ifv  = 0;
                m_ifin = NOP;
            end
        end else if (got) begin
            m_fbv  = 1;
            m_fbpc = m_inflight;
            m_fbin = imem_rdata_i;
        end

        if (resp && m_kill) m_kill = 0;
        if (flush_i && ((m_running && m_waiting && !imem_rvalid_i) || acc)) m_kill = 1;

        if (flush_i)  m_npc = branch_target_i;
        else if (acc) m_npc = old_npc + 32'd4;
        if (acc) m_inflight = old_npc;

        if (!m_running)      m_running = start_i;
        else if (!m_waiting) m_waiting = acc;
        else if (imem_rvalid_i) m_waiting = 0;
    endtask

    task automatic checkOutput();
        check32("req", {31'b0, imem_req_o}, {31'b0, model_req()});
        check32("addr", imem_addr_o, m_npc);
        check32("valid", {31'b0, if_id_valid_o}, {31'b0, m_ifv});
        check32("instr", if_id_instr_o, m_ifin);
        if (m_ifv) check32("pc", if_id_pc_o, m_ifpc);
    endtask

    // One clock: apply stimulus on the falling edge, compare, then step model and memory.
    task automatic applyStimulus();
        @(negedge clk_i);
        rst_i           = s_rst;
        start_i         = s_start;
        pc_write_i      = s_pc_write;
        stall_i         = s_stall;
        flush_i         = s_flush;
        branch_target_i = s_target;
        imem_ready_i    = s_ready;
        imem_rvalid_i   = mem_pending && s_rvalid_en;
        imem_rdata_i    = imem_rvalid_i ? instr_for(mem_addr) : 32'h0;
        if (!rst_i) model_reset();
        #1;
        checkOutput();
        if (imem_req_o && imem_ready_i) req_log.push_back(imem_addr_o);
        if (if_id_valid_o && !(prev_valid && prev_pc == if_id_pc_o)) pc_log.push_back(if_id_pc_o);
        prev_valid = if_id_valid_o;
        prev_pc    = if_id_pc_o;
        if (rst_i) model_step();
        if (imem_rvalid_i) mem_pending = 0;
        if (imem_req_o && imem_ready_i) begin
            mem_pending = 1;
            mem_addr    = imem_addr_o;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        s_rst = 0; s_start = 0; s_pc_write = 1; s_stall = 0; s_flush = 0;
        s_ready = 1; s_rvalid_en = 1; s_target = 32'h0;
        rst_i = 0; start_i = 0; pc_write_i = 1; stall_i = 0; flush_i = 0;
        branch_target_i = 0; imem_ready_i = 1; imem_rvalid_i = 0; imem_rdata_i = 0;
        mem_pending = 0; mem_addr = 0; prev_valid = 0; prev_pc = 0;
        model_reset();

        applyStimulus();
        applyStimulus();
        check32("reset_req", {31'b0, imem_req_o}, 32'h0);
        check32("reset_addr", imem_addr_o, 32'h0);
        check32("reset_instr", if_id_instr_o, NOP);
        check32("reset_valid", {31'b0, if_id_valid_o}, 32'h0);
        check32("reset_pc", if_id_pc_o, 32'h0);

        // Zero-wait streaming until the fetch of 0x8 is in flight
        s_rst = 1; s_start = 1;
        for (int k = 0; k < 20 && !(m_waiting && m_inflight == 32'h8); k++) applyStimulus();
        check32("reach_wait_8", {31'b0, m_waiting && m_inflight == 32'h8}, 32'h1);

        // Stall across the response for 0x8
        s_stall = 1;
        applyStimulus();
        applyStimulus();
        check32("stall_hold_pc", if_id_pc_o, 32'h4);
        check32("stall_no_req", {31'b0, imem_req_o}, 32'h0);
        s_stall = 0;
        applyStimulus();

        // pc_write low: no request, PC frozen at 0xC
        s_pc_write = 0;
        applyStimulus();
        check32("pc8_pc", if_id_pc_o, 32'h8);
        check32("pc8_instr", if_id_instr_o, 32'hDEAD_0008);
        check32("pc8_valid", {31'b0, if_id_valid_o}, 32'h1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus();
            check32("hold_req", {31'b0, imem_req_o}, 32'h0);
            check32("hold_addr", imem_addr_o, 32'hC);
        end
        s_pc_write = 1;
        applyStimulus();
        check32("resume_req_c", imem_addr_o, 32'hC);

        // Redirect while waiting for 0xC: its response must be dropped
        s_rvalid_en = 0; s_flush = 1; s_target = 32'h100;
        applyStimulus();
        s_flush = 0; s_rvalid_en = 1;
        applyStimulus();
        check32("flush_bubble", {31'b0, if_id_valid_o}, 32'h0);
        applyStimulus();
        check32("redirect_req", {31'b0, imem_req_o}, 32'h1);
        check32("redirect_addr", imem_addr_o, 32'h100);

        // Park 0x100 in the buffer, then flush and stall together
        s_stall = 1;
        applyStimulus();
        s_flush = 1; s_target = 32'h7FFF_FFFC;
        applyStimulus();
        s_flush = 0; s_stall = 0;
        applyStimulus();
        check32("fs_bubble", {31'b0, if_id_valid_o}, 32'h0);
        check32("fs_addr", imem_addr_o, 32'h7FFF_FFFC);
        check32("fs_req", {31'b0, imem_req_o}, 32'h1);

        // Flush on the same cycle the response arrives
        s_flush = 1; s_target = 32'hFFFF_FFFC;
        applyStimulus();
        check32("cross_2g_addr", imem_addr_o, 32'h8000_0000);
        s_flush = 0;
        applyStimulus();
        check32("same_cycle_drop", {31'b0, if_id_valid_o}, 32'h0);
        check32("top_addr", imem_addr_o, 32'hFFFF_FFFC);
        applyStimulus();
        applyStimulus();
        check32("top_pc", if_id_pc_o, 32'hFFFF_FFFC);
        check32("top_instr", if_id_instr_o, 32'h2152_FFFC);
        check32("wrap_addr", imem_addr_o, 32'h0);
        applyStimulus();
        applyStimulus();
        check32("wrap_pc", if_id_pc_o, 32'h0);
        check32("wrap_instr", if_id_instr_o, 32'hDEAD_0000);

        // Reset while the request for 0x4 is outstanding, late response after release
        s_rvalid_en = 0; s_rst = 0; s_start = 0;
        applyStimulus();
        applyStimulus();
        check32("mid_reset_valid", {31'b0, if_id_valid_o}, 32'h0);
        check32("mid_reset_addr", imem_addr_o, 32'h0);
        s_rst = 1; s_rvalid_en = 1;
        applyStimulus();
        applyStimulus();
        check32("late_rvalid_ignored", {31'b0, if_id_valid_o}, 32'h0);
        check32("idle_no_req", {31'b0, imem_req_o}, 32'h0);
        s_start = 1;
        applyStimulus();
        applyStimulus();
        check32("restart_addr", imem_addr_o, 32'h0);
        check32("restart_req", {31'b0, imem_req_o}, 32'h1);
        applyStimulus();
        applyStimulus();
        check32("restart_pc", if_id_pc_o, 32'h0);
        check32("restart_valid", {31'b0, if_id_valid_o}, 32'h1);

        // Whole-run history of accepted addresses and delivered PCs
        check32("req_log_0", req_log.size() > 2 ? req_log[0] : 32'hFFFF_FFFF, 32'h0);
        check32("req_log_1", req_log.size() > 2 ? req_log[1] : 32'hFFFF_FFFF, 32'h4);
        check32("req_log_2", req_log.size() > 2 ? req_log[2] : 32'hFFFF_FFFF, 32'h8);
        check32("pc_log_size", pc_log.size(), 32'd6);
        if (pc_log.size() == 6) begin
            check32("pc_log_1", pc_log[1], 32'h4);
            check32("pc_log_2", pc_log[2], 32'h8);
            check32("pc_log_3", pc_log[3], 32'hFFFF_FFFC);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
